// File: rtl/fault_inject_pkg.sv
// Shared types for the fault injector: corruption modes, channel states and
// the per-request attributes latched by every channel.
package fault_inject_pkg;

  typedef enum logic [1:0] {
    FLIP   = 2'd0,
    STUCK0 = 2'd1,
    STUCK1 = 2'd2,
    RAND   = 2'd3
  } fault_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2
  } fault_state_e;

  // Width-independent request attributes; mask and counts travel beside it.
  typedef struct packed {
    fault_mode_e mode;
    logic        sticky;
  } fault_req_t;

  localparam fault_req_t FaultReqReset = '{mode: FLIP, sticky: 1'b0};

endpackage

// File: rtl/fault_inject_chan.sv
// One injection channel: IDLE/DELAY/INJECT scheduler, latched request and
// the combinational corruption mux on the monitored signal.
module fault_inject_chan
  import fault_inject_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                accept_i,
  input  fault_req_t          req_i,
  input  logic [Width-1:0]    mask_i,
  input  logic [CntWidth-1:0] delay_i,
  input  logic [CntWidth-1:0] duration_i,
  input  logic                abort_i,
  input  logic [Width-1:0]    lfsr_i,
  input  logic [Width-1:0]    sig_i,
  output logic [Width-1:0]    sig_o,
  output logic                idle_o,
  output logic                inj_active_o,
  output logic                done_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  fault_state_e        state_q;
  fault_req_t          req_q;
  logic [Width-1:0]    mask_q;
  logic [CntWidth-1:0] dur_q;
  logic [CntWidth-1:0] cnt_q;
  logic                done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= FaultReqReset;
      mask_q  <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept_i) begin
              req_q  <= req_i;
              mask_q <= mask_i;
              dur_q  <= duration_i;
              if (delay_i != '0) begin
                state_q <= DELAY;
                cnt_q   <= delay_i - CntOne;
              end else begin
                state_q <= INJECT;
                cnt_q   <= duration_i - CntOne;
              end
            end
          end
          DELAY: begin
            if (cnt_q == '0) begin
              state_q <= INJECT;
              cnt_q   <= dur_q - CntOne;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          INJECT: begin
            // A sticky request ignores the counter and waits for abort.
            if (!req_q.sticky) begin
              if (cnt_q == '0) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q - CntOne;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sig_o = sig_i;
    if (state_q == INJECT) begin
      case (req_q.mode)
        FLIP:    sig_o = sig_i ^ mask_q;
        STUCK0:  sig_o = sig_i & ~mask_q;
        STUCK1:  sig_o = sig_i | mask_q;
        RAND:    sig_o = (sig_i & ~mask_q) | (lfsr_i & mask_q);
        default: sig_o = sig_i;
      endcase
    end
  end

  assign idle_o       = (state_q == IDLE);
  assign inj_active_o = (state_q == INJECT);
  assign done_o       = done_q;

endmodule

// File: rtl/prim_lfsr.sv
// Free-running Galois LFSR (right shift) with a reset seed; state is the output.
module prim_lfsr #(
  parameter int unsigned        LfsrDw      = 32,
  parameter logic [LfsrDw-1:0]  DefaultSeed = LfsrDw'(1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [LfsrDw-1:0] state_o
);

  // x^32+x^22+x^2+x+1 for 32 bits; other widths fall back to a simple
  // invertible polynomial so a non-zero seed never collapses to zero.
  localparam logic [LfsrDw-1:0] Taps = (LfsrDw == 32) ? LfsrDw'(32'h8020_0003)
                                     : ((LfsrDw'(1) << (LfsrDw - 1)) | LfsrDw'(1));

  logic [LfsrDw-1:0] lfsr_q;
  logic [LfsrDw-1:0] lfsr_d;

  assign lfsr_d  = (lfsr_q >> 1) ^ ({LfsrDw{lfsr_q[0]}} & Taps);
  assign state_o = lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= DefaultSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/fault_inject_ctrl.sv
// Multi-channel time-controlled fault injector: request routing, shared
// random-data LFSR and one scheduler/corruption channel per monitored signal.
module fault_inject_ctrl
  import fault_inject_pkg::*;
#(
  parameter int unsigned  NumChannels = 4,
  parameter int unsigned  Width       = 32,
  parameter int unsigned  CntWidth    = 16,
  parameter logic [31:0]  LfsrSeed    = 32'h1,
  localparam int unsigned ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_i,
  output logic                              req_ready_o,
  input  logic [ChanW-1:0]                  req_chan_i,
  input  logic [1:0]                        req_mode_i,
  input  logic [Width-1:0]                  req_mask_i,
  input  logic [CntWidth-1:0]               req_delay_i,
  input  logic [CntWidth-1:0]               req_duration_i,
  input  logic [NumChannels-1:0]            abort_i,
  input  logic [NumChannels-1:0][Width-1:0] sig_i,
  output logic [NumChannels-1:0][Width-1:0] sig_o,
  output logic [NumChannels-1:0]            inj_active_o,
  output logic [NumChannels-1:0]            done_o
);

  logic [NumChannels-1:0] chan_idle;
  logic [Width-1:0]       lfsr;
  logic                   accept;
  fault_req_t             req;

  prim_lfsr #(
    .LfsrDw      (Width),
    .DefaultSeed (Width'(LfsrSeed))
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_o (lfsr)
  );

  // Only the addressed channel's abort blocks the handshake.
  always_comb begin
    req_ready_o = 1'b0;
    if (32'(req_chan_i) < NumChannels) begin
      req_ready_o = chan_idle[req_chan_i] & ~abort_i[req_chan_i];
    end
  end

  assign accept     = req_i & req_ready_o;
  assign req.mode   = fault_mode_e'(req_mode_i);
  assign req.sticky = (req_duration_i == '0);

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    fault_inject_chan #(
      .Width    (Width),
      .CntWidth (CntWidth)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .accept_i     (accept && (req_chan_i == ChanW'(gi))),
      .req_i        (req),
      .mask_i       (req_mask_i),
      .delay_i      (req_delay_i),
      .duration_i   (req_duration_i),
      .abort_i      (abort_i[gi]),
      .lfsr_i       (lfsr),
      .sig_i        (sig_i[gi]),
      .sig_o        (sig_o[gi]),
      .idle_o       (chan_idle[gi]),
      .inj_active_o (inj_active_o[gi]),
      .done_o       (done_o[gi])
    );
  end

endmodule
